// File: rtl/div_tick_pkg.sv
// rtl/div_tick_pkg.sv - shared state type, reset constant and default widths for the divided-tick controller
package div_tick_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DIV_W_DEF = 8;
    localparam int NUM_W_DEF = 8;
    localparam int DIV_RST   = 4;

endpackage

// File: rtl/div_tick_phase.sv
// rtl/div_tick_phase.sv - wrapping phase counter with clear/load/enable and terminal-count flag
// ph always holds the phase of the next counted cycle; term flags that this phase ends a period.
module div_tick_phase
    import div_tick_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             term
);

    logic [DIV_W-1:0] ph;

    // >= rather than == so a stale phase can never run past the period
    assign term = (ph >= (div - DIV_W'(1)));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ph <= '0;
        end else if (load) begin
            ph <= load_val;
        end else if (en) begin
            ph <= term ? '0 : ph + DIV_W'(1);
        end
    end

endmodule

// File: rtl/div_tick_ctrl.sv
// rtl/div_tick_ctrl.sv - divided-tick sequencer top; optional DIV_TICK_CTRL_PAUSE_EN adds a pause input
// tick/done are decided one edge ahead so they leave registers with no input-to-output path.
module div_tick_ctrl
    import div_tick_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [NUM_W-1:0] cfg_num,
    input  logic             start,
    input  logic             stop,
`ifdef DIV_TICK_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    output logic             tick,
    output logic [NUM_W-1:0] tick_idx,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [DIV_W-1:0] div_r;
    logic [NUM_W-1:0] num_r;
    logic [NUM_W-1:0] tc;

    logic             cfg_hs;
    logic [DIV_W-1:0] div_in;
    logic [DIV_W-1:0] div_eff;
    logic [NUM_W-1:0] num_eff;
    logic             div_one;
    logic             run_go;
    logic             run_adv;
    logic             pause_i;
    logic             ph_clear;
    logic             ph_term;
    logic [DIV_W-1:0] ph_load_val;

`ifdef DIV_TICK_CTRL_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state == ST_RUN);
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign div_in    = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

    // a handshake in the start cycle feeds the new values straight into the run
    assign div_eff   = cfg_hs ? div_in : div_r;
    assign num_eff   = cfg_hs ? cfg_num : num_r;
    assign div_one   = (div_eff == DIV_W'(1));

    assign run_go    = (state == ST_IDLE) && start && !stop;
    assign run_adv   = (state == ST_RUN) && !stop && !done && !pause_i;
    assign ph_clear  = (state == ST_RUN) && (stop || done);

    // first RUN cycle consumes phase 0, so the counter is preloaded with the phase after it
    assign ph_load_val = div_one ? '0 : DIV_W'(1);

    div_tick_phase #(
        .DIV_W(DIV_W)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .clear    (ph_clear),
        .load     (run_go),
        .load_val (ph_load_val),
        .en       (run_adv),
        .div      (div_r),
        .term     (ph_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_r    <= DIV_W'(DIV_RST);
            num_r    <= '0;
            tc       <= '0;
            tick     <= 1'b0;
            tick_idx <= '0;
            done     <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (cfg_hs) begin
                div_r <= div_in;
                num_r <= cfg_num;
            end
            if (state == ST_IDLE) begin
                if (run_go) begin
                    state    <= ST_RUN;
                    tick     <= div_one;
                    tick_idx <= '0;
                    done     <= div_one && (num_eff == NUM_W'(1));
                    tc       <= div_one ? NUM_W'(1) : '0;
                end
            end else begin
                if (stop || done) begin
                    state <= ST_IDLE;
                end else if (!pause_i) begin
                    tick <= ph_term;
                    if (ph_term) begin
                        tick_idx <= tc;
                        tc       <= tc + NUM_W'(1);
                        done     <= (num_r != '0) && (tc == num_r - NUM_W'(1));
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_div_tick_ctrl.sv
// tb/tb_div_tick_ctrl.sv - self-checking bench for div_tick_ctrl: directed table, corner sequences, random vs model
module tb_div_tick_ctrl;

    localparam int DIV_W = 8;
    localparam int NUM_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic [NUM_W-1:0] cfg_num;
    logic             start;
    logic             stop;
    logic             pause;
    logic             tick;
    logic [NUM_W-1:0] tick_idx;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_tick_ctrl #(.DIV_W(DIV_W), .NUM_W(NUM_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_num   (cfg_num),
        .start     (start),
        .stop      (stop),
`ifdef DIV_TICK_CTRL_PAUSE_EN
        .pause     (pause),
`endif
        .tick      (tick),
        .tick_idx  (tick_idx),
        .busy      (busy),
        .done      (done)
    );

    // reference: counts active run cycles k; a tick lands on every multiple of the divide ratio
    bit m_run = 1'b0;
    int m_k = 0;
    int m_div = 4;
    int m_num = 0;
    bit e_tick = 1'b0;
    bit e_done = 1'b0;
    int e_idx = 0;

    function automatic void model_edge();
        bit act;
        act = 1'b0;
        if (rst) begin
            m_run  = 1'b0;
            m_div  = 4;
            m_num  = 0;
            e_tick = 1'b0;
            e_done = 1'b0;
            return;
        end
        if (!m_run) begin
            if (cfg_valid) begin
                m_div = (cfg_div == 0) ? 1 : int'(cfg_div);
                m_num = int'(cfg_num);
            end
            if (start && !stop) begin
                m_run = 1'b1;
                m_k   = 0;
                act   = 1'b1;
            end
        end else if (stop || e_done) begin
            m_run = 1'b0;
        end else if (!pause) begin
            act = 1'b1;
        end
        e_tick = 1'b0;
        e_done = 1'b0;
        if (act) begin
            m_k++;
            if (m_k % m_div == 0) begin
                e_tick = 1'b1;
                e_idx  = (m_k / m_div - 1) % (1 << NUM_W);
                e_done = (m_num != 0) && (m_k / m_div == m_num);
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_tick", int'(tick), int'(e_tick));
        chk("model_done", int'(done), int'(e_done));
        chk("model_busy", int'(busy), int'(m_run));
        chk("model_ready", int'(cfg_ready), int'(!m_run));
        if (e_tick) chk("model_idx", int'(tick_idx), e_idx);
    endtask

    typedef struct {
        bit cfg_same;
        int div;
        int num;
        int first;
        int per;
        int n;
        int done_off;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        bit exp_t;
        if (!v.cfg_same) begin
            cfg_valid = 1'b1;
            cfg_div   = DIV_W'(v.div);
            cfg_num   = NUM_W'(v.num);
            cycle();
            cfg_valid = 1'b0;
        end
        cfg_valid = v.cfg_same;
        cfg_div   = DIV_W'(v.div);
        cfg_num   = NUM_W'(v.num);
        start     = 1'b1;
        for (int off = 1; off <= v.done_off + 1; off++) begin
            cycle();
            start     = 1'b0;
            cfg_valid = 1'b0;
            exp_t = (off >= v.first) && ((off - v.first) % v.per == 0) && ((off - v.first) / v.per < v.n);
            chk("vec_tick", int'(tick), int'(exp_t));
            if (exp_t) chk("vec_idx", int'(tick_idx), (off - v.first) / v.per);
            chk("vec_done", int'(done), int'(off == v.done_off));
            chk("vec_busy", int'(busy), int'(off <= v.done_off));
        end
        chk("vec_ready_after", int'(cfg_ready), 1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 3, 5, 3, 3, 5, 15};
        vecs[1] = '{1'b0, 0, 2, 1, 1, 2, 2};
        vecs[2] = '{1'b1, 2, 1, 2, 2, 1, 2};
        vecs[3] = '{1'b1, 1, 1, 1, 1, 1, 1};
        vecs[4] = '{1'b0, 5, 3, 5, 5, 3, 15};

        rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_num = '0;
        start = 1'b0; stop = 1'b0; pause = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_tick", int'(tick), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(tick_idx), 0);
        chk("rst_ready", int'(cfg_ready), 1);

        // default config: continuous ticks every 4, then stop on a due tick with a pending config
        start = 1'b1;
        for (int off = 1; off <= 23; off++) begin
            cycle();
            start = 1'b0;
            chk("cont_tick", int'(tick), int'(off % 4 == 0));
            if (off % 4 == 0) chk("cont_idx", int'(tick_idx), off / 4 - 1);
            chk("cont_done", int'(done), 0);
            if (off >= 22) chk("cont_ready_low", int'(cfg_ready), 0);
            if (off == 21) begin
                cfg_valid = 1'b1; cfg_div = 8'd2; cfg_num = 8'd1;
            end
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("stop_tick", int'(tick), 0);
        chk("stop_done", int'(done), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_ready", int'(cfg_ready), 1);
        cycle();
        cfg_valid = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("pend_t1_tick", int'(tick), 0);
        cycle();
        chk("pend_t2_tick", int'(tick), 1);
        chk("pend_t2_done", int'(done), 1);
        cycle();
        chk("pend_t3_busy", int'(busy), 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // reset mid-burst, then a run with no config falls back to div 4
        cfg_valid = 1'b1; cfg_div = 8'd3; cfg_num = 8'd5;
        cycle();
        cfg_valid = 1'b0;
        start = 1'b1;
        for (int off = 1; off <= 5; off++) begin
            cycle();
            start = 1'b0;
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mrst_tick", int'(tick), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_idx", int'(tick_idx), 0);
        start = 1'b1;
        for (int off = 1; off <= 8; off++) begin
            cycle();
            start = 1'b0;
            chk("mrst_run_tick", int'(tick), int'(off % 4 == 0));
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;

`ifdef DIV_TICK_CTRL_PAUSE_EN
        cfg_valid = 1'b1; cfg_div = 8'd4; cfg_num = 8'd0;
        cycle();
        cfg_valid = 1'b0;
        start = 1'b1;
        for (int off = 1; off <= 12; off++) begin
            cycle();
            start = 1'b0;
            if (off == 1) pause = 1'b1;
            if (off == 4) pause = 1'b0;
            chk("pause_tick", int'(tick), int'(off == 7 || off == 11));
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
`endif

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = DIV_W'($urandom_range(0, 6));
            cfg_num   = NUM_W'($urandom_range(0, 4));
            start     = ($urandom_range(0, 4) == 0);
            stop      = ($urandom_range(0, 39) == 0);
`ifdef DIV_TICK_CTRL_PAUSE_EN
            pause     = ($urandom_range(0, 6) == 0);
`endif
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
